// File: rtl/ctrl_decode_pipe_if.sv
// ID-stage request and pipelined control-word bus between the datapath and ctrl_decode_pipe.
// The slave modport is the control unit; the master modport is the datapath side.
interface ctrl_decode_pipe_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned REG_W   = 5
);
    logic [OP_W-1:0]    instr_op_i;
    logic [REG_W-1:0]   rs_i;
    logic [REG_W-1:0]   rt_i;
    logic               id_valid_i;
    logic               stall_ext_i;
    logic               flush_i;
    logic               illegal_o;
    logic               hazard_stall_o;
    logic [ALUOP_W-1:0] ex_alu_op_o;
    logic               ex_alu_src_o;
    logic               ex_reg_dst_o;
    logic               ex_branch_o;
    logic               ex_jump_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               mem_branch_o;
    logic               wb_reg_write_o;
    logic               wb_mem_to_reg_o;

    modport master (
        output instr_op_i, rs_i, rt_i, id_valid_i, stall_ext_i, flush_i,
        input  illegal_o, hazard_stall_o,
        input  ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_jump_o,
        input  mem_read_o, mem_write_o, mem_branch_o,
        input  wb_reg_write_o, wb_mem_to_reg_o
    );

    modport slave (
        input  instr_op_i, rs_i, rt_i, id_valid_i, stall_ext_i, flush_i,
        output illegal_o, hazard_stall_o,
        output ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_jump_o,
        output mem_read_o, mem_write_o, mem_branch_o,
        output wb_reg_write_o, wb_mem_to_reg_o
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Main control unit: decodes the ID opcode and carries the control word through ID/EX,
// EX/MEM and MEM/WB, inserting bubbles for load-use hazards, flushes and idle slots.
module ctrl_decode_pipe #(
    parameter int unsigned OP_W         = 6,
    parameter int unsigned ALUOP_W      = 4,
    parameter int unsigned REG_W        = 5,
    parameter bit          LOAD_USE_EN  = 1'b1,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    ctrl_decode_pipe_if.slave bus
);
    if (ALUOP_W < 4) begin : gParamCheck
        $error("ctrl_decode_pipe: ALUOP_W must be at least 4");
    end

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_BR1   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BR6   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

    typedef struct packed {
        logic [ALUOP_W-1:0] aluOp;
        logic               aluSrc;
        logic               regDst;
        logic               regWrite;
        logic               branch;
        logic               jump;
        logic               memRead;
        logic               memWrite;
        logic               memToReg;
    } exWord_t;

    typedef struct packed {
        logic regWrite;
        logic branch;
        logic memRead;
        logic memWrite;
        logic memToReg;
    } memWord_t;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wbWord_t;

    exWord_t           decWord;
    logic              opKnown;
    logic              hazardStall;
    exWord_t           exReg;
    logic [REG_W-1:0]  exRt;
    memWord_t          memReg;
    wbWord_t           wbReg;

    // Opcode decode; unknown opcodes fall through to the all-zero NOP word.
    always_comb begin
        decWord = '0;
        opKnown = 1'b1;
        case (bus.instr_op_i)
            OP_RTYPE: begin decWord.regDst = 1'b1; decWord.regWrite = 1'b1; end
            OP_BR1:   begin decWord.aluOp = ALUOP_W'(10); decWord.branch = 1'b1; end
            OP_J:     begin decWord.aluOp = ALUOP_W'(9);  decWord.jump = 1'b1; end
            OP_BEQ:   begin decWord.aluOp = ALUOP_W'(1);  decWord.branch = 1'b1; end
            OP_BNE:   begin decWord.aluOp = ALUOP_W'(4);  decWord.branch = 1'b1; end
            OP_BR6:   begin decWord.aluOp = ALUOP_W'(11); decWord.branch = 1'b1; end
            OP_ADDI:  begin decWord.aluOp = ALUOP_W'(2); decWord.aluSrc = 1'b1; decWord.regWrite = 1'b1; end
            OP_SLTI:  begin decWord.aluOp = ALUOP_W'(3); decWord.aluSrc = 1'b1; decWord.regWrite = 1'b1; end
            OP_ORI:   begin decWord.aluOp = ALUOP_W'(5); decWord.aluSrc = 1'b1; decWord.regWrite = 1'b1; end
            OP_LUI:   begin decWord.aluOp = ALUOP_W'(6); decWord.aluSrc = 1'b1; decWord.regWrite = 1'b1; end
            OP_LW: begin
                decWord.aluOp    = ALUOP_W'(7);
                decWord.aluSrc   = 1'b1;
                decWord.regWrite = 1'b1;
                decWord.memRead  = 1'b1;
                decWord.memToReg = 1'b1;
            end
            OP_SW: begin
                decWord.aluOp    = ALUOP_W'(8);
                decWord.aluSrc   = 1'b1;
                decWord.memWrite = 1'b1;
            end
            default: opKnown = 1'b0;
        endcase
    end

    // rt is compared for every opcode; a false stall only costs one cycle.
    assign hazardStall = LOAD_USE_EN & bus.id_valid_i & exReg.memRead & (exRt != '0)
                       & ((exRt == bus.rs_i) | (exRt == bus.rt_i));

    assign bus.illegal_o      = ILLEGAL_TRAP & bus.id_valid_i & ~opKnown;
    assign bus.hazard_stall_o = hazardStall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exReg  <= '0;
            exRt   <= '0;
            memReg <= '0;
            wbReg  <= '0;
        end else if (!bus.stall_ext_i) begin
            memReg <= '{regWrite: exReg.regWrite, branch: exReg.branch, memRead: exReg.memRead,
                        memWrite: exReg.memWrite, memToReg: exReg.memToReg};
            wbReg  <= '{regWrite: memReg.regWrite, memToReg: memReg.memToReg};
            if (hazardStall || bus.flush_i || !bus.id_valid_i) begin
                exReg <= '0;
                exRt  <= '0;
            end else begin
                exReg <= decWord;
                exRt  <= bus.rt_i;
            end
        end
    end

    assign bus.ex_alu_op_o     = exReg.aluOp;
    assign bus.ex_alu_src_o    = exReg.aluSrc;
    assign bus.ex_reg_dst_o    = exReg.regDst;
    assign bus.ex_branch_o     = exReg.branch;
    assign bus.ex_jump_o       = exReg.jump;
    assign bus.mem_read_o      = memReg.memRead;
    assign bus.mem_write_o     = memReg.memWrite;
    assign bus.mem_branch_o    = memReg.branch;
    assign bus.wb_reg_write_o  = wbReg.regWrite;
    assign bus.wb_mem_to_reg_o = wbReg.memToReg;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed-vector bench for ctrl_decode_pipe: each row's expected outputs are queued by the
// driver and checked by an independent monitor on the falling edge.
module tb_ctrl_decode_pipe;
    logic clk;
    logic rst;

    ctrl_decode_pipe_if #(.OP_W(6), .ALUOP_W(4), .REG_W(5)) bus ();
    ctrl_decode_pipe_if #(.OP_W(6), .ALUOP_W(4), .REG_W(5)) busNoTrap ();

    ctrl_decode_pipe #(.OP_W(6), .ALUOP_W(4), .REG_W(5), .LOAD_USE_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.slave)
    );

    ctrl_decode_pipe #(.OP_W(6), .ALUOP_W(4), .REG_W(5), .LOAD_USE_EN(1'b1), .ILLEGAL_TRAP(1'b0)) dutNoTrap (
        .clk_i(clk), .rst_i(rst), .bus(busNoTrap.slave)
    );

    assign busNoTrap.instr_op_i  = bus.instr_op_i;
    assign busNoTrap.rs_i        = bus.rs_i;
    assign busNoTrap.rt_i        = bus.rt_i;
    assign busNoTrap.id_valid_i  = bus.id_valid_i;
    assign busNoTrap.stall_ext_i = bus.stall_ext_i;
    assign busNoTrap.flush_i     = bus.flush_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, se, fl, v;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       eIll, eHaz;
        logic [7:0] eEx;   // {alu_op[3:0], alu_src, reg_dst, branch, jump}
        logic [2:0] eMem;  // {mem_read, mem_write, mem_branch}
        logic [1:0] eWb;   // {reg_write, mem_to_reg}
    } vec_t;

    typedef struct {
        int         row;
        logic       eIll, eHaz;
        logic [7:0] eEx;
        logic [2:0] eMem;
        logic [1:0] eWb;
    } exp_t;

    vec_t vecQ[$];
    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic addV(input logic r, se, fl, v, input logic [5:0] op, input logic [4:0] rs, rt,
                        input logic eIll, eHaz, input logic [7:0] eEx, input logic [2:0] eMem,
                        input logic [1:0] eWb);
        vec_t x;
        x = '{rst: r, se: se, fl: fl, v: v, op: op, rs: rs, rt: rt,
              eIll: eIll, eHaz: eHaz, eEx: eEx, eMem: eMem, eWb: eWb};
        vecQ.push_back(x);
    endtask

    task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    // Monitor: compares the live outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("illegal", e.row, 8'(bus.illegal_o), 8'(e.eIll));
                check("hazard", e.row, 8'(bus.hazard_stall_o), 8'(e.eHaz));
                check("ex_word", e.row, {bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_dst_o,
                                         bus.ex_branch_o, bus.ex_jump_o}, e.eEx);
                check("mem_word", e.row, 8'({bus.mem_read_o, bus.mem_write_o, bus.mem_branch_o}), 8'(e.eMem));
                check("wb_word", e.row, 8'({bus.wb_reg_write_o, bus.wb_mem_to_reg_o}), 8'(e.eWb));
                check("illegal_notrap", e.row, 8'(busNoTrap.illegal_o), 8'h00);
            end
        end
    end

    // Driver
    initial begin
        vec_t x;
        exp_t e;
        rst = 1'b1;
        bus.instr_op_i  = 6'd35;
        bus.rs_i        = '0;
        bus.rt_i        = 5'd5;
        bus.id_valid_i  = 1'b1;
        bus.stall_ext_i = 1'b0;
        bus.flush_i     = 1'b0;

        //   rst se fl v  op   rs  rt  ill haz ex     mem   wb
        addV(1, 0, 0, 1, 35,  0,  5,  0,  0,  8'h00, 3'd0, 2'd0); // reset, LW presented
        addV(0, 0, 0, 1, 35,  0,  5,  0,  0,  8'h00, 3'd0, 2'd0);
        addV(0, 0, 0, 1,  0,  1,  2,  0,  0,  8'h78, 3'd0, 2'd0); // LW in EX
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h04, 3'd4, 2'd0);
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h00, 3'd0, 2'd3); // LW reaches WB
        addV(0, 0, 0, 1,  0,  1,  2,  0,  0,  8'h00, 3'd0, 2'd2); // stream R, ADDI, SW, J
        addV(0, 0, 0, 1,  8,  1,  3,  0,  0,  8'h04, 3'd0, 2'd0);
        addV(0, 0, 0, 1, 43,  1,  4,  0,  0,  8'h28, 3'd0, 2'd0);
        addV(0, 0, 0, 1,  2,  1,  2,  0,  0,  8'h88, 3'd0, 2'd2);
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h91, 3'd2, 2'd2); // J in EX, SW MemWrite
        addV(0, 0, 0, 1, 35,  1,  5,  0,  0,  8'h00, 3'd0, 2'd0); // LW rt=5
        addV(0, 0, 0, 1,  0,  5,  2,  0,  1,  8'h78, 3'd0, 2'd0); // R rs=5: load-use stall
        addV(0, 0, 0, 1,  0,  5,  2,  0,  0,  8'h00, 3'd4, 2'd0); // bubble in EX
        addV(0, 0, 0, 1, 35,  1,  0,  0,  0,  8'h04, 3'd0, 2'd3); // LW rt=0
        addV(0, 0, 0, 1,  0,  0,  0,  0,  0,  8'h78, 3'd0, 2'd0); // rs=rt=0: no stall
        addV(0, 0, 1, 1,  4,  1,  2,  0,  0,  8'h04, 3'd4, 2'd2); // BEQ flushed
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h00, 3'd0, 2'd3);
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h00, 3'd0, 2'd2);
        addV(0, 0, 0, 1, 35,  1,  7,  0,  0,  8'h00, 3'd0, 2'd0); // fill pipe
        addV(0, 0, 0, 1,  8,  2,  3,  0,  0,  8'h78, 3'd0, 2'd0);
        addV(0, 0, 0, 1, 43,  1,  4,  0,  0,  8'h28, 3'd4, 2'd0);
        addV(0, 1, 0, 1,  4,  1,  2,  0,  0,  8'h88, 3'd0, 2'd3); // external stall x3
        addV(0, 1, 0, 1,  4,  1,  2,  0,  0,  8'h88, 3'd0, 2'd3);
        addV(0, 1, 0, 1,  4,  1,  2,  0,  0,  8'h88, 3'd0, 2'd3);
        addV(0, 0, 0, 1,  4,  1,  2,  0,  0,  8'h88, 3'd0, 2'd3);
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h12, 3'd2, 2'd2); // resumed shifting
        addV(0, 0, 0, 1, 35,  1,  6,  0,  0,  8'h00, 3'd1, 2'd0);
        addV(0, 0, 1, 1,  0,  2,  6,  0,  1,  8'h78, 3'd0, 2'd0); // flush with hazard
        addV(0, 0, 0, 1, 63,  0,  0,  1,  0,  8'h00, 3'd4, 2'd0); // illegal opcode
        addV(0, 0, 0, 0, 63,  0,  0,  0,  0,  8'h00, 3'd0, 2'd3); // invalid slot: no trap
        addV(0, 0, 0, 1, 35,  0,  9,  0,  0,  8'h00, 3'd0, 2'd0);
        addV(1, 1, 0, 1,  0,  9,  1,  0,  1,  8'h78, 3'd0, 2'd0); // reset mid-hazard under stall
        addV(0, 0, 0, 1,  0,  9,  1,  0,  0,  8'h00, 3'd0, 2'd0);
        addV(0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h04, 3'd0, 2'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecQ.size(); i++) begin
            x = vecQ[i];
            rst             = x.rst;
            bus.stall_ext_i = x.se;
            bus.flush_i     = x.fl;
            bus.id_valid_i  = x.v;
            bus.instr_op_i  = x.op;
            bus.rs_i        = x.rs;
            bus.rt_i        = x.rt;
            e = '{row: i, eIll: x.eIll, eHaz: x.eHaz, eEx: x.eEx, eMem: x.eMem, eWb: x.eWb};
            expQ.push_back(e);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Pipelined main-control unit for the 5-stage CPU. It decodes the ID-stage opcode into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB registers. It owns load-use hazard detection, bubble insertion and branch/jump flush, so the datapath pipeline registers carry data only. It also flags illegal opcodes.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 4, ALU_op field width; must be at least 4
REG_W, 5, register-specifier width
LOAD_USE_EN, 1, 1 = internal load-use stall/bubble enabled; 0 = hazard_stall_o tied 0
ILLEGAL_TRAP, 1, 1 = unknown opcode asserts illegal_o and decodes as NOP; 0 = decodes as NOP silently

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
instr_op_i  in  OP_W  ID-stage opcode (instr[31:26])
rs_i  in  REG_W  ID-stage rs
rt_i  in  REG_W  ID-stage rt
id_valid_i  in  1  ID stage holds a real instruction
stall_ext_i  in  1  external stall (e.g. memory wait); freezes all three stages
flush_i  in  1  branch-taken flush from EX; kills the instruction in ID
illegal_o  out  1  combinational: valid ID opcode not in table (ILLEGAL_TRAP=1 only)
hazard_stall_o  out  1  combinational load-use stall; holds PC and IF/ID
ex_alu_op_o  out  ALUOP_W  ID/EX ALU_op
ex_alu_src_o  out  1  ID/EX ALUSrc
ex_reg_dst_o  out  1  ID/EX RegDst
ex_branch_o  out  1  ID/EX Branch
ex_jump_o  out  1  ID/EX Jump, active-high
mem_read_o  out  1  EX/MEM MemRead
mem_write_o  out  1  EX/MEM MemWrite
mem_branch_o  out  1  EX/MEM Branch
wb_reg_write_o  out  1  MEM/WB RegWrite
wb_mem_to_reg_o  out  1  MEM/WB MemtoReg, 1 = select memory data

Behaviour:
- Decode table (opcode: ALU_op, ALUSrc, RegDst, RegWrite, Branch, Jump, MemRead, MemWrite, MemtoReg):
  - 0 R-type: 0,0,1,1,0,0,0,0,0
  - 1: 10,0,0,0,1,0,0,0,0
  - 2 J: 9,0,0,0,0,1,0,0,0
  - 4 BEQ: 1,0,0,0,1,0,0,0,0
  - 5 BNE: 4,0,0,0,1,0,0,0,0
  - 6: 11,0,0,0,1,0,0,0,0
  - 8 ADDI: 2,1,0,1,0,0,0,0,0
  - 10 SLTI: 3,1,0,1,0,0,0,0,0
  - 13 ORI: 5,1,0,1,0,0,0,0,0
  - 15 LUI: 6,1,0,1,0,0,0,0,0
  - 35 LW: 7,1,0,1,0,0,1,0,1
  - 43 SW: 8,1,0,0,0,0,0,1,0
- NOP word: every field 0. Also used for bubble, flush, reset and illegal opcodes.
- Reset (rst_i=1 at an edge): all three stage registers become NOP, so every registered output is 0. Reset overrides stall and flush, including mid-hazard.
- Latency: the decoded word appears on the ex_* outputs 1 cycle after ID, on the mem_* outputs after 2 cycles, and on the wb_* outputs after 3 cycles.
- Load-use hazard: hazard_stall_o = LOAD_USE_EN & id_valid_i & ex MemRead & (ex_rt != 0) & (ex_rt == rs_i | ex_rt == rt_i).
  - ex_rt is rt_i captured into ID/EX.
  - The rt compare is conservative for all opcodes.
- Per-edge priority, highest first:
  1. rst_i.
  2. stall_ext_i: all stages hold.
  3. Otherwise EX/MEM takes ID/EX and MEM/WB takes EX/MEM. ID/EX loads NOP if hazard_stall_o, flush_i or !id_valid_i is true; otherwise it loads the decoded word.
- flush_i and hazard together: the result is a NOP in ID/EX. hazard_stall_o is still reported; the upstream flush wins at the PC.
- The bubble lasts exactly 1 cycle. After the bubble ex MemRead=0, so the hazard deasserts automatically.
- illegal_o depends only on the current ID inputs. It is not registered and is not gated by stall.

Test Plan:
- Reset with opcode 35 presented, rst_i=1 for 2 cycles → all outputs 0. After release, LW is decoded: ex_alu_op_o=7, ex_alu_src_o=1. Two cycles later wb_mem_to_reg_o=1 and wb_reg_write_o=1.
- Stream R-type, ADDI, SW, J on consecutive cycles → ex_alu_op_o takes 0, 2, 8, 9 on consecutive cycles. mem_write_o pulses 1 exactly 2 cycles after SW enters ID. ex_jump_o=1 only for J.
- LW with rt=5, then R-type with rs=5 → hazard_stall_o=1 for 1 cycle and one NOP enters ID/EX. The R-type is decoded on the next cycle. Repeat with rt=0 → no stall.
- flush_i=1 with BEQ in ID → ex_branch_o stays 0 and a NOP propagates to wb_* two cycles later.
- stall_ext_i=1 for 3 cycles with a full pipe → every output is frozen. The pipe resumes shifting on the first cycle after deassertion.
- Opcode 63 with id_valid_i=1 → illegal_o=1 and a NOP is registered. With ILLEGAL_TRAP=0, illegal_o=0.
